// File: rtl/squarer_pkg.sv
// Shared constants and FSM state encoding for the iterative squarer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package squarer_pkg;

    localparam int ROOT_WIDTH_DEF   = 8;
    localparam int SQUARE_WIDTH_DEF = 16;
    localparam int ODD_WIDTH_DEF    = ROOT_WIDTH_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/squarer_ctrl.sv
// Controller FSM for the squarer: sequences load, iterate and done.
// Latency: start accepted in IDLE; CALC lasts until the datapath reports no more work.
// Backpressure: none; start_i is ignored outside IDLE. Optional SQUARER_VERIFY_EN adds finish_o.
module squarer_ctrl
    import squarer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic more_i,
    output logic load_o,
    output logic step_o,
`ifdef SQUARER_VERIFY_EN
    output logic finish_o,
`endif
    output logic busy_o,
    output logic done_o
);

    state_e state_q, state_d;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; the unused code falls back to IDLE.
    always_comb begin
        state_d = state_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
`ifdef SQUARER_VERIFY_EN
        finish_o = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_o = 1'b1;
                if (more_i) begin
                    step_o = 1'b1;
                end else begin
`ifdef SQUARER_VERIFY_EN
                    finish_o = 1'b1;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/squarer_dp.sv
// Squarer datapath: square += odd, odd += 2, counter -= 1 per step.
// Latency: one register update per step strobe.
// Backpressure: none. SQUARER_VERIFY_EN adds a next-square accumulator, one extra step and ok_o.
module squarer_dp
    import squarer_pkg::*;
#(
    parameter int ROOT_WIDTH   = ROOT_WIDTH_DEF,
    parameter int SQUARE_WIDTH = SQUARE_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic [ROOT_WIDTH-1:0]   root_i,
`ifdef SQUARER_VERIFY_EN
    input  logic                    finish_i,
    input  logic [SQUARE_WIDTH-1:0] valor_i,
    output logic                    ok_o,
`endif
    output logic [SQUARE_WIDTH-1:0] square_o,
    output logic                    more_o
);

    localparam int ODD_W = ROOT_WIDTH + 2;

    logic [ROOT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SQUARE_WIDTH-1:0] sq_q, sq_d;
    logic [ODD_W-1:0]        odd_q, odd_d;
    logic                    cnt_zero;

`ifdef SQUARER_VERIFY_EN
    localparam int NXT_W = SQUARE_WIDTH + 1;
    logic [NXT_W-1:0]        nxt_q, nxt_d;
    logic [SQUARE_WIDTH-1:0] val_q, val_d;
    logic                    ext_q, ext_d;
    logic                    ok_q, ok_d;
`endif

    assign cnt_zero = (cnt_q == '0);
    assign square_o = sq_q;

`ifdef SQUARER_VERIFY_EN
    // After N steps one extra step adds 2N+1 to the next-square copy only.
    assign more_o = !cnt_zero || !ext_q;
    assign ok_o   = ok_q;
`else
    assign more_o = !cnt_zero;
`endif

    // Next-state for the accumulator, odd term and down-counter.
    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        odd_d = odd_q;
`ifdef SQUARER_VERIFY_EN
        nxt_d = nxt_q;
        val_d = val_q;
        ext_d = ext_q;
        ok_d  = ok_q;
`endif
        if (load_i) begin
            cnt_d = root_i;
            sq_d  = '0;
            odd_d = ODD_W'(1);
`ifdef SQUARER_VERIFY_EN
            nxt_d = '0;
            val_d = valor_i;
            ext_d = 1'b0;
            ok_d  = 1'b0;
`endif
        end else if (step_i) begin
            if (!cnt_zero) begin
                sq_d  = sq_q + SQUARE_WIDTH'(odd_q);
                odd_d = odd_q + ODD_W'(2);
                cnt_d = cnt_q - ROOT_WIDTH'(1);
`ifdef SQUARER_VERIFY_EN
                nxt_d = nxt_q + NXT_W'(odd_q);
            end else begin
                nxt_d = nxt_q + NXT_W'(odd_q);
                ext_d = 1'b1;
`endif
            end
        end
`ifdef SQUARER_VERIFY_EN
        if (finish_i) begin
            ok_d = (sq_q <= val_q) && ({1'b0, val_q} < nxt_q);
        end
`endif
    end

    // Datapath registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sq_q  <= '0;
            odd_q <= '0;
`ifdef SQUARER_VERIFY_EN
            nxt_q <= '0;
            val_q <= '0;
            ext_q <= 1'b0;
            ok_q  <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
            odd_q <= odd_d;
`ifdef SQUARER_VERIFY_EN
            nxt_q <= nxt_d;
            val_q <= val_d;
            ext_q <= ext_d;
            ok_q  <= ok_d;
`endif
        end
    end

endmodule

// File: rtl/squarer_seq.sv
// Iterative squarer (sum of odd numbers), N*N with start/busy/done handshake.
// Latency: done_o high N+1 cycles after start accepted (N+2 with SQUARER_VERIFY_EN).
// Backpressure: none; start_i only sampled in IDLE, no queuing.
module squarer_seq
    import squarer_pkg::*;
#(
    parameter int ROOT_WIDTH   = ROOT_WIDTH_DEF,
    parameter int SQUARE_WIDTH = SQUARE_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ROOT_WIDTH-1:0]   root_i,
`ifdef SQUARER_VERIFY_EN
    input  logic [SQUARE_WIDTH-1:0] valor_i,
    output logic                    ok_o,
`endif
    output logic [SQUARE_WIDTH-1:0] square_o,
    output logic                    busy_o,
    output logic                    done_o
);

    logic load, step, more;
`ifdef SQUARER_VERIFY_EN
    logic finish;
`endif

    squarer_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .more_i   (more),
        .load_o   (load),
        .step_o   (step),
`ifdef SQUARER_VERIFY_EN
        .finish_o (finish),
`endif
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    squarer_dp #(
        .ROOT_WIDTH   (ROOT_WIDTH),
        .SQUARE_WIDTH (SQUARE_WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .root_i   (root_i),
`ifdef SQUARER_VERIFY_EN
        .finish_i (finish),
        .valor_i  (valor_i),
        .ok_o     (ok_o),
`endif
        .square_o (square_o),
        .more_o   (more)
    );

endmodule

// File: tb/tb_squarer_seq.sv
// Directed testbench for squarer_seq with immediate-assertion checks.
// Latency: checks latency N+1 (N+2 with SQUARER_VERIFY_EN).
// Backpressure: exercises start_i ignored during CALC.
module tb_squarer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  root_i;
    logic [15:0] square_o;
    logic        busy_o;
    logic        done_o;
`ifdef SQUARER_VERIFY_EN
    logic [15:0] valor_i;
    logic        ok_o;
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    int checks   = 0;
    int failures = 0;
    int lat, bsy, dn;

    squarer_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .root_i   (root_i),
`ifdef SQUARER_VERIFY_EN
        .valor_i  (valor_i),
        .ok_o     (ok_o),
`endif
        .square_o (square_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] r);
        root_i  = r;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Counts edges from the accepting edge until done_o; optionally pokes start mid-CALC.
    task automatic wait_done(input int poke_at, output int l, output int b);
        l = 0;
        b = 0;
        while (!done_o && l < 600) begin
            if (busy_o) b++;
            if (l == poke_at) begin
                start_i = 1'b1;
                root_i  = 8'd3;
            end
            if (l == poke_at + 2) start_i = 1'b0;
            tick();
            l++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        root_i  = 8'd0;
`ifdef SQUARER_VERIFY_EN
        valor_i = 16'd0;
`endif
        tick();
        tick();
        chk("reset_square", 32'(square_o), 32'd0);
        chk("reset_busy",   32'(busy_o),   32'd0);
        chk("reset_done",   32'(done_o),   32'd0);
`ifdef SQUARER_VERIFY_EN
        chk("reset_ok",     32'(ok_o),     32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // N = 0
        start_op(8'd0);
        wait_done(-10, lat, bsy);
        chk("n0_latency", 32'(lat), 32'(1 + EXTRA));
        chk("n0_busy",    32'(bsy), 32'(1 + EXTRA));
        chk("n0_square",  32'(square_o), 32'd0);
        chk("n0_busy_at_done", 32'(busy_o), 32'd0);
        tick();
        chk("n0_done_pulse", 32'(done_o), 32'd0);

        // N = 5
        start_op(8'd5);
        wait_done(-10, lat, bsy);
        chk("n5_latency", 32'(lat), 32'(6 + EXTRA));
        chk("n5_busy",    32'(bsy), 32'(6 + EXTRA));
        chk("n5_square",  32'(square_o), 32'd25);
        tick();
        tick();
        tick();
        chk("n5_hold", 32'(square_o), 32'd25);
        chk("n5_done_low", 32'(done_o), 32'd0);

        // N = 255, then back-to-back N = 1
        start_op(8'd255);
        chk("n255_cleared", 32'(square_o), 32'd0);
        wait_done(-10, lat, bsy);
        chk("n255_latency", 32'(lat), 32'(256 + EXTRA));
        chk("n255_square",  32'(square_o), 32'd65025);
        tick();
        chk("n255_hold_idle", 32'(square_o), 32'd65025);
        start_op(8'd1);
        wait_done(-10, lat, bsy);
        chk("n1_latency", 32'(lat), 32'(2 + EXTRA));
        chk("n1_square",  32'(square_o), 32'd1);
        tick();

        // N = 10 with a start request (root 3) during CALC
        start_op(8'd10);
        wait_done(3, lat, bsy);
        chk("n10_latency", 32'(lat), 32'(11 + EXTRA));
        chk("n10_square",  32'(square_o), 32'd100);
        tick();
        tick();
        chk("n10_no_restart", 32'(busy_o), 32'd0);

        // N = 200 abandoned by reset mid-flight, then N = 4
        start_op(8'd200);
        dn = 0;
        for (int i = 0; i < 49; i++) begin
            if (done_o) dn++;
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("abort_square", 32'(square_o), 32'd0);
        chk("abort_busy",   32'(busy_o),   32'd0);
        chk("abort_done",   32'(done_o),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done_o) dn++;
            tick();
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_idle",    32'(busy_o), 32'd0);
        start_op(8'd4);
        wait_done(-10, lat, bsy);
        chk("n4_latency", 32'(lat), 32'(5 + EXTRA));
        chk("n4_square",  32'(square_o), 32'd16);
        tick();

`ifdef SQUARER_VERIFY_EN
        valor_i = 16'd30;
        start_op(8'd5);
        wait_done(-10, lat, bsy);
        chk("v30_latency", 32'(lat), 32'd7);
        chk("v30_square",  32'(square_o), 32'd25);
        chk("v30_ok",      32'(ok_o), 32'd1);
        tick();
        chk("v30_ok_hold", 32'(ok_o), 32'd1);

        valor_i = 16'd36;
        start_op(8'd5);
        chk("v36_ok_cleared", 32'(ok_o), 32'd0);
        wait_done(-10, lat, bsy);
        chk("v36_ok", 32'(ok_o), 32'd0);
        tick();

        valor_i = 16'd25;
        start_op(8'd5);
        wait_done(-10, lat, bsy);
        chk("v25_ok", 32'(ok_o), 32'd1);
        tick();

        valor_i = 16'd65535;
        start_op(8'd255);
        wait_done(-10, lat, bsy);
        chk("v65535_square", 32'(square_o), 32'd65025);
        chk("v65535_ok",     32'(ok_o), 32'd1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
